// File: rtl/fetch_queue.sv
// Prefetch FIFO between fetch and decode: stores {PC, instruction} pairs with a
// valid/ready head, full-stall, and flush. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 9,
  parameter int PC_W    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [PC_W-1:0]    pc_mem_d    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];
  logic [DEPTH-1:0]   wr_en;

  logic not_empty;
  logic full;
  logic bypass_active;
  logic bypass_take;
  logic pop;
  logic push;

  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == CW'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_active = ~not_empty & in_valid & ~flush;
`else
    bypass_active = 1'b0;
`endif
    // A bypassed entry that decode takes immediately never touches storage.
    bypass_take = bypass_active & out_ready;
    pop         = not_empty & out_ready & ~flush;
    push        = in_valid & ~flush & (~full | pop) & ~bypass_take;
  end

  always_comb begin
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign wr_en[gi] = push & (wr_ptr_q == AW'(gi));

      always_comb begin
        pc_mem_d[gi]    = pc_mem_q[gi];
        instr_mem_d[gi] = instr_mem_q[gi];
        if (wr_en[gi]) begin
          pc_mem_d[gi]    = in_pc;
          instr_mem_d[gi] = in_instr;
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          pc_mem_q[gi]    <= '0;
          instr_mem_q[gi] <= '0;
        end else begin
          pc_mem_q[gi]    <= pc_mem_d[gi];
          instr_mem_q[gi] <= instr_mem_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Head data is forced to zero when nothing is presented.
  always_comb begin
    out_valid = not_empty | bypass_active;
    out_pc    = '0;
    out_instr = '0;
    if (not_empty) begin
      out_pc    = pc_mem_q[rd_ptr_q];
      out_instr = instr_mem_q[rd_ptr_q];
    end else if (bypass_active) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
    stall = full;
    count = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH   = 4;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic [PC_W-1:0]    in_pc = '0;
  logic [INSTR_W-1:0] in_instr = '0;
  logic               flush = 1'b0;
  logic               out_ready = 1'b0;
  logic               out_valid;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               stall;
  logic [2:0]         count;

  fetch_queue #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .stall(stall), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ent_t;

  ent_t model_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    ent_t head;
    logic v;
    v = 1'b0;
    head = '0;
    if (model_q.size() > 0) begin
      v = 1'b1;
      head = model_q[0];
    end else if (BYP && in_valid && !flush) begin
      v = 1'b1;
      head.pc = in_pc;
      head.instr = in_instr;
    end
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".pc"},    32'(out_pc),    32'(head.pc));
    check({tag, ".instr"}, 32'(out_instr), 32'(head.instr));
    check({tag, ".count"}, 32'(count),     32'(model_q.size()));
    check({tag, ".stall"}, 32'(stall),     32'(model_q.size() == DEPTH));
  endtask

  // Reference: queue semantics straight from the handshake rules.
  task automatic model_update();
    ent_t e;
    bit full;
    e.pc = in_pc;
    e.instr = in_instr;
    if (flush) begin
      model_q.delete();
    end else if (BYP && model_q.size() == 0 && in_valid) begin
      if (out_ready) $display("pop pc=%02h instr=%03h (bypass)", in_pc, in_instr);
      else model_q.push_back(e);
    end else begin
      full = (model_q.size() == DEPTH);
      if (model_q.size() > 0 && out_ready) begin
        $display("pop pc=%02h instr=%03h", model_q[0].pc, model_q[0].instr);
        void'(model_q.pop_front());
        if (in_valid) model_q.push_back(e);
      end else if (in_valid && !full) begin
        model_q.push_back(e);
      end
    end
  endtask

  task automatic cycle(input string tag, input logic v, input logic [PC_W-1:0] pc,
                       input logic fl, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = {1'b1, pc ^ 8'h5A};
    flush     = fl;
    out_ready = rdy;
    #1;
    check_outputs(tag);
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 2 * DEPTH && model_q.size() > 0; k++)
      cycle(tag, 1'b0, 8'h00, 1'b0, 1'b1);
    check({tag, ".empty"}, 32'(count), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    reset = 1'b0;

    // 1: asynchronous reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) cycle("t1_fill", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    check("t1_count3", 32'(count), 32'd3);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    model_q.delete();
    check_outputs("t1_rst");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 2: fill to full, blocked fifth push, then in-order drain
    for (int i = 0; i < 4; i++) cycle("t2_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    cycle("t2_blocked", 1'b1, 8'h04, 1'b0, 1'b0);
    check("t2_count", 32'(count), 32'd4);
    check("t2_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t2_order", 32'(out_pc), 32'(i));
      cycle("t2_pop", 1'b0, 8'h00, 1'b0, 1'b1);
    end
    check("t2_empty", 32'(out_valid), 32'd0);

    // 3: push and pop together while full
    for (int i = 0; i < 4; i++) cycle("t3_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    cycle("t3_pp", 1'b1, 8'h04, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("t3_count", 32'(count), 32'd4);
    check("t3_head", 32'(out_pc), 32'h01);
    drain("t3_drain");

    // 4: streaming, pointers wrap three times
    for (int i = 0; i < 12; i++) cycle("t4_stream", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b1);
    drain("t4_drain");

    // 5: flush beats simultaneous push and pop
    for (int i = 0; i < 3; i++) cycle("t5_fill", 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    cycle("t5_flush", 1'b1, 8'h33, 1'b1, 1'b1);
    in_valid = 1'b0;
    check("t5_count", 32'(count), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);

    // 6: single entry into an empty queue with decode ready
    cycle("t6_push", 1'b1, 8'h20, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("t6_pc", 32'(out_pc), BYP ? 32'h0 : 32'h20);
    drain("t6_drain");

    // random traffic
    for (int n = 0; n < 3000; n++)
      cycle("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
